// File: rtl/mvau_weight_stream_ctrl_if.sv
// Weight stream from the MVAU weight sequencer to one PE's compute lanes.
// The master drives the word, its valid and its end-of-pass flag; the slave drives ready.
interface mvau_weight_stream_ctrl_if #(
    parameter int unsigned DW = 2
);
    logic [DW-1:0] w_out;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;

    modport master (output w_out, output w_valid, output w_last, input w_ready);
    modport slave  (input w_out, input w_valid, input w_last, output w_ready);
endinterface

// File: rtl/mvau_weight_stream_ctrl.sv
// Weight memory sequencer for one MVAU PE: walks the memory NUM_REPS times per start,
// absorbs the 1-cycle read latency and streams words through a 2-entry skid FIFO.
module mvau_weight_stream_ctrl #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4,
    parameter int unsigned NUM_REPS     = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    mvau_weight_stream_ctrl_if.master w_s
);
    localparam int unsigned WW     = SIMD * TW;
    localparam int unsigned REP_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [WMEM_ADDR_BW-1:0] addr_q;
    logic [REP_BW-1:0]       rep_q;
    logic                    inflight_q;
    logic                    inflight_last_q;

    logic [WW-1:0]           fifo_data [2];
    logic                    fifo_last [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              fifo_cnt;

    logic                    push, pop, issue, done_c;
    logic                    addr_at_last, rep_at_last;
    logic [2:0]              occ;

    assign push         = inflight_q;
    assign pop          = w_s.w_valid & w_s.w_ready;
    assign addr_at_last = (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
    assign rep_at_last  = (rep_q == REP_BW'(NUM_REPS - 1));

    // Words already owned (queued or in flight) must leave room for the one about to be read.
    assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q};
    assign issue = (state_q == S_RUN) && (occ < (3'd2 + {2'b00, pop}));

    // The final word is the only one that can sit at the head with nothing in flight in DRAIN.
    assign done_c = (state_q == S_DRAIN) && pop && w_s.w_last && !inflight_q;

    assign wmem_addr   = addr_q;
    assign w_s.w_valid = (fifo_cnt != 2'd0);
    assign w_s.w_out   = fifo_data[rd_ptr];
    assign w_s.w_last  = w_s.w_valid & fifo_last[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: a default assignment first keeps this combinational block from inferring latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (issue && addr_at_last && rep_at_last) state_d = S_DRAIN;
            S_DRAIN: if (done_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_c;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q          <= '0;
            rep_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue & addr_at_last;
            if (state_q == S_IDLE && start) begin
                addr_q <= '0;
                rep_q  <= '0;
            end else if (issue) begin
                if (addr_at_last) begin
                    addr_q <= '0;
                    rep_q  <= rep_at_last ? '0 : rep_q + 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    // NOTE: the two FIFO slots are reset because the head drives w_out, which must read 0 out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= wmem_in;
                fifo_last[wr_ptr] <= inflight_last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_mvau_weight_stream_ctrl.sv
// Bench for the MVAU weight sequencer: a cycle table for the basic run, scenario runs
// checked against a queue model, a mid-run reset, and a wide single-rep instance.
module tb_mvau_weight_stream_ctrl;
    localparam int A_DEPTH = 4;
    localparam int A_REPS  = 2;
    localparam int A_WORDS = A_DEPTH * A_REPS;
    localparam int B_DEPTH = 5;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [3:0]  wmem_addr_a, wmem_addr_b;
    logic [1:0]  wmem_in_a = '0;
    logic [15:0] wmem_in_b = '0;
    logic [1:0]  mem_a [16];
    logic [15:0] mem_b [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    mvau_weight_stream_ctrl_if #(.DW(2))  ws_a ();
    mvau_weight_stream_ctrl_if #(.DW(16)) ws_b ();

    mvau_weight_stream_ctrl dut_a (
        .aclk(aclk), .aresetn(aresetn), .start(start_a), .busy(busy_a), .done(done_a),
        .wmem_addr(wmem_addr_a), .wmem_in(wmem_in_a), .w_s(ws_a.master)
    );

    mvau_weight_stream_ctrl #(
        .SIMD(4), .TW(4), .WMEM_DEPTH(B_DEPTH), .WMEM_ADDR_BW(4), .NUM_REPS(1)
    ) dut_b (
        .aclk(aclk), .aresetn(aresetn), .start(start_b), .busy(busy_b), .done(done_b),
        .wmem_addr(wmem_addr_b), .wmem_in(wmem_in_b), .w_s(ws_b.master)
    );

    // Synchronous-read weight memories with one cycle of latency.
    always @(posedge aclk) begin
        wmem_in_a <= mem_a[wmem_addr_a];
        wmem_in_b <= mem_b[wmem_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       busy;
        logic       valid;
        logic [1:0] data;
        logic       last;
        logic       done;
    } vec_t;

    typedef struct {
        int mode;          // 0 ready high, 1 toggle, 2 five-cycle stall, 3 random
        int extra_start;   // cycle of a re-pulsed start while busy, 0 for none
        bit start_in_done; // raise start in the done cycle
        int exp_words;
        int exp_dones;
    } scen_t;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } word_t;

    function automatic logic ready_pattern(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return !(cyc >= 6 && cyc < 11);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One run on DUT A; the expected stream is every address in order, once per rep.
    task automatic run_stream(input int mode, input int extra_start, input bit start_in_done,
                              input int exp_words, input int exp_dones);
        word_t exp_q[$];
        int    words = 0;
        int    dones = 0;
        int    cyc = 0;
        bit    finished = 0;
        bit    stalled = 0;
        for (int a = 0; a < 16; a++) mem_a[a] = 2'($urandom_range(0, 3));
        for (int r = 0; r < A_REPS; r++)
            for (int a = 0; a < A_DEPTH; a++)
                exp_q.push_back('{data: 32'(mem_a[a]), last: (a == A_DEPTH - 1)});
        while (!finished && cyc < 200) begin
            @(posedge aclk); #1;
            start_a = (cyc == 0) || (extra_start != 0 && cyc == extra_start);
            ws_a.w_ready = ready_pattern(mode, cyc);
            @(negedge aclk);
            if (cyc == 0) begin
                check("idle_busy_at_start", 32'(busy_a), 32'd0);
                check("idle_addr_at_start", 32'(wmem_addr_a), 32'd0);
            end
            if (stalled) check("valid_held_in_stall", 32'(ws_a.w_valid), 32'd1);
            if (ws_a.w_valid) begin
                if (exp_q.size() == 0) begin
                    check("word_beyond_run", 32'd1, 32'd0);
                end else begin
                    check("head_data", 32'(ws_a.w_out), exp_q[0].data);
                    check("head_last", 32'(ws_a.w_last), 32'(exp_q[0].last));
                end
            end
            if (ws_a.w_valid && ws_a.w_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                words++;
                check("done_on_final", 32'(done_a), 32'(exp_q.size() == 0));
            end else begin
                check("done_spurious", 32'(done_a), 32'd0);
            end
            if (done_a) begin
                dones++;
                finished = 1;
                if (start_in_done) start_a = 1'b1;
            end
            stalled = ws_a.w_valid && !ws_a.w_ready;
            cyc++;
        end
        check("run_completed", 32'(finished), 32'd1);
        check("word_count", 32'(words), 32'(exp_words));
        check("done_count", 32'(dones), 32'(exp_dones));
    endtask

    vec_t  vecs[12];
    scen_t scens[7];

    initial begin
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 1, 0, 0, 0};
        vecs[4]  = '{0, 1, 1, 1, 1, 0, 0};
        vecs[5]  = '{0, 1, 1, 1, 2, 0, 0};
        vecs[6]  = '{0, 1, 1, 1, 3, 1, 0};
        vecs[7]  = '{0, 1, 1, 1, 0, 0, 0};
        vecs[8]  = '{0, 1, 1, 1, 1, 0, 0};
        vecs[9]  = '{0, 1, 1, 1, 2, 0, 0};
        vecs[10] = '{0, 1, 1, 1, 3, 1, 1};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 0};

        scens[0] = '{0, 0, 0, A_WORDS, 1};
        scens[1] = '{1, 0, 0, A_WORDS, 1};
        scens[2] = '{2, 0, 0, A_WORDS, 1};
        scens[3] = '{3, 4, 0, A_WORDS, 1};
        scens[4] = '{0, 5, 1, A_WORDS, 1};
        scens[5] = '{3, 0, 0, A_WORDS, 1};
        scens[6] = '{2, 2, 1, A_WORDS, 1};

        for (int a = 0; a < 16; a++) begin
            mem_a[a] = 2'(a);
            mem_b[a] = 16'hA000 + 16'(a);
        end
        ws_a.w_ready = 1'b0;
        ws_b.w_ready = 1'b0;

        // Reset values.
        #12;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_addr", 32'(wmem_addr_a), 32'd0);
        check("rst_valid", 32'(ws_a.w_valid), 32'd0);
        check("rst_last", 32'(ws_a.w_last), 32'd0);
        check("rst_wout", 32'(ws_a.w_out), 32'd0);
        check("rst_b_valid", 32'(ws_b.w_valid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Basic run, cycle by cycle, memory holding 0,1,2,3.
        for (int k = 0; k < 12; k++) begin
            @(posedge aclk); #1;
            start_a      = vecs[k].start;
            ws_a.w_ready = vecs[k].ready;
            @(negedge aclk);
            check($sformatf("vec%0d_busy", k), 32'(busy_a), 32'(vecs[k].busy));
            check($sformatf("vec%0d_valid", k), 32'(ws_a.w_valid), 32'(vecs[k].valid));
            check($sformatf("vec%0d_done", k), 32'(done_a), 32'(vecs[k].done));
            if (vecs[k].valid) begin
                check($sformatf("vec%0d_data", k), 32'(ws_a.w_out), 32'(vecs[k].data));
                check($sformatf("vec%0d_last", k), 32'(ws_a.w_last), 32'(vecs[k].last));
            end
        end
        check("addr_after_done", 32'(wmem_addr_a), 32'd0);

        // Scenario runs, each starting on the cycle after the previous done.
        for (int s = 0; s < 7; s++)
            run_stream(scens[s].mode, scens[s].extra_start, scens[s].start_in_done,
                       scens[s].exp_words, scens[s].exp_dones);

        // Mid-run reset after the third accepted word.
        begin
            int words = 0;
            int cyc = 0;
            while (words < 3 && cyc < 50) begin
                @(posedge aclk); #1;
                start_a      = (cyc == 0);
                ws_a.w_ready = 1'b1;
                @(negedge aclk);
                if (ws_a.w_valid && ws_a.w_ready) words++;
                cyc++;
            end
            check("reset_reached_word3", 32'(words), 32'd3);
        end
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_addr", 32'(wmem_addr_a), 32'd0);
        check("midrst_valid", 32'(ws_a.w_valid), 32'd0);
        check("midrst_last", 32'(ws_a.w_last), 32'd0);
        check("midrst_wout", 32'(ws_a.w_out), 32'd0);
        @(negedge aclk);
        check("midrst_no_done", 32'(done_a), 32'd0);
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        run_stream(0, 0, 0, A_WORDS, 1);
        @(posedge aclk); #1;
        start_a = 1'b0;

        // Wide single-rep instance: five words A000..A004, last and done on the fifth.
        begin
            int idx = 0;
            int cyc = 0;
            int dones = 0;
            int first_valid = -1;
            bit finished = 0;
            while (!finished && cyc < 60) begin
                @(posedge aclk); #1;
                start_b      = (cyc == 0);
                ws_b.w_ready = 1'b1;
                @(negedge aclk);
                if (ws_b.w_valid && first_valid < 0) first_valid = cyc;
                if (ws_b.w_valid && ws_b.w_ready) begin
                    check("b_data", 32'(ws_b.w_out), 32'h0000_A000 + 32'(idx));
                    check("b_last", 32'(ws_b.w_last), 32'(idx == B_DEPTH - 1));
                    check("b_done", 32'(done_b), 32'(idx == B_DEPTH - 1));
                    idx++;
                end
                if (done_b) begin
                    dones++;
                    finished = 1;
                end
                cyc++;
            end
            check("b_finished", 32'(finished), 32'd1);
            check("b_word_count", 32'(idx), 32'(B_DEPTH));
            check("b_done_count", 32'(dones), 32'd1);
            check("b_first_valid_cycle", 32'(first_valid), 32'd3);
            @(posedge aclk); #1;
            start_b = 1'b0;
            @(negedge aclk);
            check("b_busy_after_done", 32'(busy_b), 32'd0);
            check("b_addr_after_done", 32'(wmem_addr_b), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mvau_weight_stream_ctrl.md
Name: mvau_weight_stream_ctrl

Overview:
- Sequencer for one MVAU weight memory: generates `wmem_addr`, absorbs the memory's fixed 1-cycle read latency, and presents weights as a valid/ready stream to the MVAU datapath.
- Each `start` walks the memory from address 0 to WMEM_DEPTH-1, repeated NUM_REPS times (once per output pixel).
- Sits between the weight memory and the MVAU compute lanes, one instance per PE.

Parameters:
- SIMD, 2, weight lanes per memory word.
- TW, 1, bits per weight.
- WMEM_DEPTH, 4, words per pass (KDim^2*IFMCh*OFMCh/(SIMD*PE)); must be >= 2.
- WMEM_ADDR_BW, 4, address width; must satisfy 2^WMEM_ADDR_BW >= WMEM_DEPTH.
- NUM_REPS, 2, passes per start; must be >= 1.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle request to begin a run; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when the last word of the last pass is accepted downstream.
- `wmem_addr` out WMEM_ADDR_BW: read address to the weight memory.
- `wmem_in` in SIMD*TW: memory read data, valid one cycle after the address is presented.
- `w_out` out SIMD*TW: weight word to the datapath.
- `w_valid` out 1: `w_out` is valid.
- `w_ready` in 1: datapath accepts the word.
- `w_last` out 1: qualifies `w_out` as the final word of a pass (address WMEM_DEPTH-1).

Behaviour:
- Reset values: `busy`=0, `done`=0, `wmem_addr`=0, `w_valid`=0, `w_last`=0, `w_out`=0, FSM in IDLE.
- Reset asserted mid-run aborts immediately: FIFO flushed, in-flight read discarded, counters cleared, and no `done` is generated.
- FSM states and transitions:
  - IDLE: on `start`, go to RUN and clear the address and rep counters.
  - RUN: issue reads. After the issue of address WMEM_DEPTH-1 on rep NUM_REPS-1, go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty, then pulse `done` and return to IDLE.
- `done` timing: `done` is asserted in the same cycle as the final handshake (`w_valid` & `w_ready` & `w_last` on the last rep). `busy` deasserts on the following cycle.
- Issue: `issue` = (state==RUN) & (fifo_cnt + inflight - pop < 2), where `pop` = `w_valid` & `w_ready`.
- On `issue`:
  - `inflight` is set for the next cycle, tagged with last = (addr == WMEM_DEPTH-1).
  - `wmem_addr` advances registered. It wraps from WMEM_DEPTH-1 to 0 and increments the rep counter on wrap.
- With no issue, `wmem_addr` holds. The memory reads every cycle, but data is captured only when `inflight` is set.
- Capture: when `inflight` is set, {`wmem_in`, tag} is written into a 2-entry FIFO. Simultaneous push and pop is legal and leaves the count unchanged.
- Outputs:
  - `w_valid` = fifo_cnt != 0.
  - `w_out` and `w_last` are driven from the FIFO head.
  - Head data stays stable while `w_valid` & !`w_ready`.
- Throughput and latency:
  - Throughput is 1 word/cycle when `w_ready` is held high.
  - First `w_valid` occurs 3 cycles after the `start` cycle (start → RUN → read issued → captured).
- Words leave in address order with no loss or duplication under any `w_ready` pattern. Total words per run = WMEM_DEPTH*NUM_REPS.
- After `done`, `wmem_addr` is 0. A `start` in the `done` cycle is ignored. A `start` on the cycle after `done` is accepted.

Test Plan:
- Basic run: defaults, memory holds 0,1,2,3, `w_ready`=1 constant, pulse `start` → stream 0,1,2,3,0,1,2,3 on consecutive cycles; `w_last` on both 3s; `done` with the second 3; `busy` low the next cycle.
- Backpressure: `w_ready` toggles 1,0,1,0 and also holds 0 for 5 cycles mid-pass → same 8-word order; `w_out` stable while stalled; FIFO never exceeds 2; no words dropped.
- Ignored start: `start` re-pulsed while `busy` → exactly 8 words and a single `done`.
- Back-to-back runs: `start` on the cycle after `done` → second identical 8-word run; `wmem_addr` restarts at 0.
- Mid-run reset: `aresetn` dropped after the 3rd word → all outputs return to reset values within the reset cycle; no `done`; a new `start` then yields a full 8-word run from word 0.
- Single rep, wider word: NUM_REPS=1, WMEM_DEPTH=5, SIMD=4, TW=4, contents 16'hA000..16'hA004 → 5 words in order; `w_last` only on 16'hA004; `done` coincident with it.
